// File: rtl/cpu_pkg.sv
// Shared definitions for the CS220 datapath front end.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
//
// Contents: datapath widths, the halt opcode, opcode field position and the
// fetch FSM state encoding.
package cpu_pkg;

  localparam int PC_W    = 5;
  localparam int INSTR_W = 32;

  // Opcode lives in the top six bits of every instruction word.
  localparam int OPC_HI = 31;
  localparam int OPC_LO = 26;
  localparam int OPC_W  = OPC_HI - OPC_LO + 1;

  localparam logic [OPC_W-1:0] HALT_OP = 6'b111111;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_t;

endpackage : cpu_pkg

// File: rtl/imem_1w1r.sv
// Instruction memory: one synchronous write port, one asynchronous read port.
// Latency: read is combinational; write lands at the rising edge.
// Backpressure: none; both ports are always available.
//
// Ports:
//   i_clk            clock
//   i_we/i_waddr/i_wdata  program-load write port
//   i_raddr          read address
//   o_rdata          read data (reflects contents before any write at this edge)
module imem_1w1r
  import cpu_pkg::*;
#(
  parameter int ADDR_W = cpu_pkg::PC_W,
  parameter int DATA_W = cpu_pkg::INSTR_W
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  // Contents are deliberately not reset; the program is loaded explicitly.
  logic [DATA_W-1:0] r_mem [2**ADDR_W];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule : imem_1w1r

// File: rtl/instr_fetch.sv
// Instruction fetch: owns the PC, reads imem and presents {pc, instr} to decode.
// Latency: 1 cycle from fetch PC to registered output; 1 bubble after a redirect.
// Backpressure: valid/ready; output and fetch PC hold while o_out_valid && !i_out_ready.
//
// Ports:
//   i_clk, i_rst_n                       clock, async active-low reset
//   i_imem_we/i_imem_waddr/i_imem_wdata  program load into instruction memory
//   i_redir_valid/i_redir_pc             taken branch/jump; flushes the output
//   o_out_valid/i_out_ready              output handshake
//   o_out_pc/o_out_instr                 delivered PC and instruction
//   o_halted                             fetch stopped on the halt opcode
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int               PC_W     = cpu_pkg::PC_W,
  parameter int               INSTR_W  = cpu_pkg::INSTR_W,
  parameter logic [PC_W-1:0]  RESET_PC = '0,
  parameter logic [OPC_W-1:0] HALT_OP  = cpu_pkg::HALT_OP
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_imem_we,
  input  logic [PC_W-1:0]    i_imem_waddr,
  input  logic [INSTR_W-1:0] i_imem_wdata,
  input  logic               i_redir_valid,
  input  logic [PC_W-1:0]    i_redir_pc,
  output logic               o_out_valid,
  input  logic               i_out_ready,
  output logic [PC_W-1:0]    o_out_pc,
  output logic [INSTR_W-1:0] o_out_instr,
  output logic               o_halted
);

  localparam logic [PC_W-1:0] PC_ONE = 1;

  fetch_state_t        r_state;
  fetch_state_t        w_state_nxt;
  logic [PC_W-1:0]     r_fetch_pc;
  logic                r_out_valid;
  logic [PC_W-1:0]     r_out_pc;
  logic [INSTR_W-1:0]  r_out_instr;

  logic [INSTR_W-1:0]  w_rd_data;
  logic                w_load;
  logic                w_is_halt;

  imem_1w1r #(
    .ADDR_W (PC_W),
    .DATA_W (INSTR_W)
  ) u_imem (
    .i_clk   (i_clk),
    .i_we    (i_imem_we),
    .i_waddr (i_imem_waddr),
    .i_wdata (i_imem_wdata),
    .i_raddr (r_fetch_pc),
    .o_rdata (w_rd_data)
  );

  // A new word may enter the output register when running, the slot is free
  // or being drained this cycle, and no redirect is flushing it.
  assign w_load    = (r_state == ST_RUN) && (!r_out_valid || i_out_ready) && !i_redir_valid;
  assign w_is_halt = (w_rd_data[OPC_HI:OPC_LO] == HALT_OP);

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: redirect always resumes running; a loaded halt word parks us.
  always_comb begin
    w_state_nxt = r_state;
    if (i_redir_valid) begin
      w_state_nxt = ST_RUN;
    end else if (w_load && w_is_halt) begin
      w_state_nxt = ST_HALT;
    end
  end

  // PC and output register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fetch_pc  <= RESET_PC;
      r_out_valid <= 1'b0;
      r_out_pc    <= '0;
      r_out_instr <= '0;
    end else if (i_redir_valid) begin
      // Flush even a held (unaccepted) instruction.
      r_out_valid <= 1'b0;
      r_fetch_pc  <= i_redir_pc;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_pc    <= r_fetch_pc;
      r_out_instr <= w_rd_data;
      // The halt word is delivered but the PC stays on it until redirected.
      if (!w_is_halt) begin
        r_fetch_pc <= r_fetch_pc + PC_ONE;
      end
    end else if (r_out_valid && i_out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign o_out_valid = r_out_valid;
  assign o_out_pc    = r_out_pc;
  assign o_out_instr = r_out_instr;
  assign o_halted    = (r_state == ST_HALT);

endmodule : instr_fetch

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

  localparam int DEPTH = 32;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_imem_we = 1'b0;
  logic [4:0]  i_imem_waddr = '0;
  logic [31:0] i_imem_wdata = '0;
  logic        i_redir_valid = 1'b0;
  logic [4:0]  i_redir_pc = '0;
  logic        o_out_valid;
  logic        i_out_ready = 1'b0;
  logic [4:0]  o_out_pc;
  logic [31:0] o_out_instr;
  logic        o_halted;

  int errors = 0;
  int checks = 0;

  // Reference model: memory image, next-fetch address, run flag, output slot.
  logic [31:0] m_mem [DEPTH];
  int          m_fpc;
  bit          m_run;
  bit          m_vld;
  int          m_pc;
  logic [31:0] m_ins;

  instr_fetch dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_imem_we    (i_imem_we),
    .i_imem_waddr (i_imem_waddr),
    .i_imem_wdata (i_imem_wdata),
    .i_redir_valid(i_redir_valid),
    .i_redir_pc   (i_redir_pc),
    .o_out_valid  (o_out_valid),
    .i_out_ready  (i_out_ready),
    .o_out_pc     (o_out_pc),
    .o_out_instr  (o_out_instr),
    .o_halted     (o_halted)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [31:0] rand_nonhalt();
    logic [31:0] w;
    w = $urandom;
    if (w[31:26] == 6'h3f) w[31] = 1'b0;
    return w;
  endfunction

  function automatic void model_reset();
    m_fpc = 0; m_run = 1; m_vld = 0; m_pc = 0; m_ins = '0;
  endfunction

  // One clock of behaviour from the current inputs, as the datapath is described.
  function automatic void model_edge();
    logic [31:0] word;
    bit          take;
    word = m_mem[m_fpc];
    take = m_run && (!m_vld || i_out_ready) && !i_redir_valid;
    if (i_redir_valid) begin
      m_vld = 0; m_fpc = int'(i_redir_pc); m_run = 1;
    end else if (take) begin
      m_vld = 1; m_pc = m_fpc; m_ins = word;
      if (word[31:26] == 6'h3f) m_run = 0;
      else m_fpc = (m_fpc + 1) % DEPTH;
    end else if (m_vld && i_out_ready) begin
      m_vld = 0;
    end
    if (i_imem_we) m_mem[i_imem_waddr] = i_imem_wdata;
  endfunction

  // Advance one edge, then compare DUT against the model on the falling edge.
  task automatic step(input string tag);
    model_edge();
    @(posedge i_clk);
    @(negedge i_clk);
    checks++;
    if (o_out_valid !== m_vld) begin
      errors++;
      $display("FAIL %s valid: got %b want %b", tag, o_out_valid, m_vld);
    end
    checks++;
    if (o_halted !== !m_run) begin
      errors++;
      $display("FAIL %s halted: got %b want %b", tag, o_halted, !m_run);
    end
    if (m_vld) begin
      checks++;
      if (o_out_pc !== 5'(m_pc) || o_out_instr !== m_ins) begin
        errors++;
        $display("FAIL %s data: got pc=%0d instr=%h want pc=%0d instr=%h",
                 tag, o_out_pc, o_out_instr, m_pc, m_ins);
      end
    end
  endtask

  // Directed expectation with constants from the scenario.
  task automatic expect_out(input string tag, input bit vld, input int pc, input logic [31:0] ins);
    checks++;
    if (o_out_valid !== vld || (vld && (o_out_pc !== 5'(pc) || o_out_instr !== ins))) begin
      errors++;
      $display("FAIL %s: got v=%b pc=%0d instr=%h want v=%b pc=%0d instr=%h",
               tag, o_out_valid, o_out_pc, o_out_instr, vld, pc, ins);
    end
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_rst_n = 1'b0; i_redir_valid = 1'b0; i_imem_we = 1'b0;
    model_reset();
    @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (o_out_valid !== 1'b0 || o_halted !== 1'b0 || o_out_pc !== 5'd0 || o_out_instr !== 32'd0) begin
      errors++;
      $display("FAIL reset_state: got v=%b h=%b pc=%0d instr=%h want all zero",
               o_out_valid, o_halted, o_out_pc, o_out_instr);
    end
    // Program load happens while held in reset; memory ignores reset.
    for (int a = 0; a < DEPTH; a++) begin
      logic [31:0] w;
      case (a)
        0: w = 32'h11;
        1: w = 32'h22;
        2: w = 32'h33;
        3: w = 32'h44;
        5: w = 32'hFC00_0000;
        default: w = rand_nonhalt();
      endcase
      @(negedge i_clk);
      i_imem_we = 1'b1; i_imem_waddr = 5'(a); i_imem_wdata = w;
      m_mem[a] = w;
    end
    @(negedge i_clk);
    i_imem_we = 1'b0;
    checks++;
    if (o_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: got valid=%b want 0", o_out_valid);
    end
  endtask

  task automatic test_stream();
    logic [31:0] exp_w [4];
    exp_w[0] = 32'h11; exp_w[1] = 32'h22; exp_w[2] = 32'h33; exp_w[3] = 32'h44;
    do_reset();
    i_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step("stream");
      expect_out("stream_const", 1'b1, i, exp_w[i]);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    i_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) step("bp_fill");
    i_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step("bp_hold");
      expect_out("bp_hold_const", 1'b1, 2, 32'h33);
    end
    i_out_ready = 1'b1;
    step("bp_resume");
    expect_out("bp_resume_const", 1'b1, 3, 32'h44);
  endtask

  task automatic test_redirect();
    do_reset();
    i_out_ready = 1'b1;
    step("redir_fill");
    step("redir_fill");
    expect_out("redir_pc1", 1'b1, 1, 32'h22);
    i_out_ready = 1'b0; i_redir_valid = 1'b1; i_redir_pc = 5'd20;
    step("redir_bubble");
    expect_out("redir_bubble_const", 1'b0, 0, 32'h0);
    i_redir_valid = 1'b0;
    step("redir_target");
    expect_out("redir_target_const", 1'b1, 20, m_mem[20]);
    i_out_ready = 1'b1;
    step("redir_next");
    expect_out("redir_next_const", 1'b1, 21, m_mem[21]);
  endtask

  task automatic test_wrap();
    i_out_ready = 1'b1; i_redir_valid = 1'b1; i_redir_pc = 5'd30;
    step("wrap_redir");
    i_redir_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      int p;
      p = (30 + i) % DEPTH;
      step("wrap");
      expect_out("wrap_const", 1'b1, p, m_mem[p]);
    end
  endtask

  task automatic test_halt();
    do_reset();
    i_out_ready = 1'b1;
    for (int i = 0; i < 6; i++) step("halt_run");
    expect_out("halt_deliver", 1'b1, 5, 32'hFC00_0000);
    checks++;
    if (o_halted !== 1'b1) begin
      errors++;
      $display("FAIL halt_flag: got %b want 1", o_halted);
    end
    for (int i = 0; i < 3; i++) begin
      step("halt_idle");
      expect_out("halt_no_pc6", 1'b0, 0, 32'h0);
    end
    i_redir_valid = 1'b1; i_redir_pc = 5'd0;
    step("halt_redir");
    checks++;
    if (o_halted !== 1'b0) begin
      errors++;
      $display("FAIL halt_clear: got %b want 0", o_halted);
    end
    i_redir_valid = 1'b0;
    step("halt_restart");
    expect_out("halt_restart_const", 1'b1, 0, 32'h11);
  endtask

  task automatic test_async_reset();
    do_reset();
    i_out_ready = 1'b1;
    for (int i = 0; i < 6; i++) step("ar_run");
    #2;
    i_rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (o_out_valid !== 1'b0 || o_halted !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got v=%b h=%b want 0 0", o_out_valid, o_halted);
    end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    step("ar_release");
    expect_out("ar_first", 1'b1, 0, 32'h11);
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      i_out_ready   = ($urandom_range(0, 9) < 7);
      i_redir_valid = ($urandom_range(0, 9) == 0);
      i_redir_pc    = 5'($urandom_range(0, DEPTH - 1));
      i_imem_we     = ($urandom_range(0, 4) == 0);
      i_imem_waddr  = 5'($urandom_range(0, DEPTH - 1));
      i_imem_wdata  = ($urandom_range(0, 7) == 0) ? {6'h3f, 26'($urandom)} : rand_nonhalt();
      step("random");
    end
    i_redir_valid = 1'b0; i_imem_we = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_halt();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_instr_fetch
